// File: rtl/mapping_group_pkg.sv
// Shared widths, mode encoding and shift helper for the mapping group datapath.
package mapping_group_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int CODE_W = 2;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 2;
    localparam int PACK_W = LANES * CODE_W;
    localparam int SUM_W  = 2 * PACK_W;
    localparam int SHF_W  = 5;

    localparam logic MODE_RBR = 1'b0;
    localparam logic MODE_PAR = 1'b1;

    // Row-by-row steps the sum by one code (2 bits); parallel steps by two codes (4 bits).
    function automatic logic [SHF_W-1:0] shift_amount(input logic mode, input logic [CNT_W-1:0] cnt);
        return (mode == MODE_PAR) ? {1'b0, cnt, 2'b00} : {2'b00, cnt, 1'b0};
    endfunction

endpackage

// File: rtl/mapping_group_thermo_decoder.sv
// Thermometer lane decoder: number of zero bits in a byte, saturated at 3.
module thermo_decoder
    import mapping_group_pkg::*;
(
    input  logic [LANE_W-1:0] i_byte,
    output logic [CODE_W-1:0] o_code
);

    logic [3:0] w_zeros;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_zeros = '0;
        for (int i = 0; i < LANE_W; i++) begin
            w_zeros = w_zeros + {3'b000, ~i_byte[i]};
        end
        o_code = (w_zeros > 4'd3) ? {CODE_W{1'b1}} : w_zeros[CODE_W-1:0];
    end

endmodule

// File: rtl/mapping_group.sv
// Buffers thermometer lanes, decodes them into 2-bit codes, shift-accumulates the
// packed codes and emits (accumulator - zero point) on load.
module mapping_group
    import mapping_group_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [LANES*LANE_W-1:0] output_i,
    input  logic                    buf_write_en_1_i,
    input  logic                    buf_write_en_2_i,
    input  logic                    buf_read_en_i,
    input  logic                    shift_counter_en_i,
    input  logic                    mode_i,
    input  logic                    accum_buf_write_i,
    input  logic                    zero_point_en_i,
    input  logic [ACC_W-1:0]        zero_point_i,
    input  logic                    load_en_i,
    output logic [ACC_W-1:0]        mapping_group_o
);

    logic [LANES*LANE_W-1:0] r_buf1;
    logic [LANES*LANE_W-1:0] r_buf2;
    logic [SUM_W-1:0]        r_sum;
    logic [ACC_W-1:0]        r_acc;
    logic [ACC_W-1:0]        r_zero_point;
    logic [ACC_W-1:0]        r_result;
    logic [CNT_W-1:0]        r_cnt;

    logic [PACK_W-1:0]       w_pack1;
    logic [PACK_W-1:0]       w_pack2;
    logic [ACC_W-1:0]        w_shifted;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        thermo_decoder u_dec1 (
            .i_byte (r_buf1[k*LANE_W +: LANE_W]),
            .o_code (w_pack1[k*CODE_W +: CODE_W])
        );
        thermo_decoder u_dec2 (
            .i_byte (r_buf2[k*LANE_W +: LANE_W]),
            .o_code (w_pack2[k*CODE_W +: CODE_W])
        );
    end

    assign w_shifted = {{(ACC_W-SUM_W){1'b0}}, r_sum} << shift_amount(mode_i, r_cnt);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_buf1       <= '0;
            r_buf2       <= '0;
            r_sum        <= '0;
            r_zero_point <= '0;
        end else begin
            if (buf_write_en_1_i) r_buf1 <= output_i;
            if (buf_write_en_2_i) r_buf2 <= output_i;
            if (zero_point_en_i)  r_zero_point <= zero_point_i;
            if (buf_read_en_i) begin
                r_sum <= (mode_i == MODE_PAR) ? {w_pack2, w_pack1} : {{PACK_W{1'b0}}, w_pack1};
            end
        end
    end

    // Load takes priority: it discards a concurrent add and counter step.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (load_en_i) begin
            r_result <= r_acc - r_zero_point;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else begin
            if (accum_buf_write_i)  r_acc <= r_acc + w_shifted;
            if (shift_counter_en_i) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign mapping_group_o = r_result;

endmodule

// File: tb/tb_mapping_group.sv
// Directed + scoreboard bench for mapping_group: a behavioural model pushes expected
// results on every load, and each load's output is popped and compared.
module tb_mapping_group;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] output_i;
    logic        buf_write_en_1_i;
    logic        buf_write_en_2_i;
    logic        buf_read_en_i;
    logic        shift_counter_en_i;
    logic        mode_i;
    logic        accum_buf_write_i;
    logic        zero_point_en_i;
    logic [31:0] zero_point_i;
    logic        load_en_i;
    logic [31:0] mapping_group_o;

    mapping_group dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .output_i           (output_i),
        .buf_write_en_1_i   (buf_write_en_1_i),
        .buf_write_en_2_i   (buf_write_en_2_i),
        .buf_read_en_i      (buf_read_en_i),
        .shift_counter_en_i (shift_counter_en_i),
        .mode_i             (mode_i),
        .accum_buf_write_i  (accum_buf_write_i),
        .zero_point_en_i    (zero_point_en_i),
        .zero_point_i       (zero_point_i),
        .load_en_i          (load_en_i),
        .mapping_group_o    (mapping_group_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    logic [31:0] m_b1, m_b2, m_acc, m_zp;
    logic [15:0] m_sum;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lane code = zeros in the byte, capped at 3, packed lane0 in the low bits.
    function automatic logic [7:0] pk(input logic [31:0] w);
        logic [7:0] r;
        int         z;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            z = $countones(~w[8*k +: 8]);
            if (z > 3) z = 3;
            r[2*k +: 2] = 2'(z);
        end
        return r;
    endfunction

    task automatic reset_model();
        m_b1 = '0; m_b2 = '0; m_acc = '0; m_zp = '0; m_sum = '0; m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic idle();
        buf_write_en_1_i = 0; buf_write_en_2_i = 0; buf_read_en_i = 0;
        shift_counter_en_i = 0; accum_buf_write_i = 0; zero_point_en_i = 0; load_en_i = 0;
    endtask

    // Applies one clock edge worth of behaviour to the model from the driven inputs.
    task automatic model_step();
        if (load_en_i) begin
            exp_q.push_back(m_acc - m_zp);
            m_acc = '0;
            m_cnt = 0;
        end else begin
            if (accum_buf_write_i) m_acc = m_acc + ({16'h0000, m_sum} << ((mode_i ? 4 : 2) * m_cnt));
            if (shift_counter_en_i) m_cnt = (m_cnt + 1) % 4;
        end
        if (buf_read_en_i) m_sum = mode_i ? {pk(m_b2), pk(m_b1)} : {8'h00, pk(m_b1)};
        if (zero_point_en_i)  m_zp = zero_point_i;
        if (buf_write_en_1_i) m_b1 = output_i;
        if (buf_write_en_2_i) m_b2 = output_i;
    endtask

    task automatic tick(input string tag);
        logic did_load;
        did_load = load_en_i;
        model_step();
        @(posedge clk_i);
        #1;
        if (did_load) check(tag, mapping_group_o, exp_q.pop_front());
        idle();
    endtask

    task automatic set_zp(input logic [31:0] v);
        zero_point_en_i = 1; zero_point_i = v;
        tick("set_zp");
    endtask

    // One row-by-row pass: capture, decode, then accumulate and advance the counter.
    task automatic rbr_pass(input logic [31:0] data);
        buf_write_en_1_i = 1; output_i = data;  tick("w1");
        buf_read_en_i = 1;                      tick("read");
        accum_buf_write_i = 1; shift_counter_en_i = 1; tick("accum");
    endtask

    task automatic do_load(input string tag);
        load_en_i = 1;
        tick(tag);
    endtask

    initial begin
        logic [31:0] wa, wb;
        rst_i = 1; idle(); output_i = '0; zero_point_i = '0; mode_i = 0;
        reset_model();
        #3;
        check("reset_out", mapping_group_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 0;

        // Four identical row-by-row passes with a non-zero zero point.
        set_zp(32'd10);
        for (int p = 0; p < 4; p++) rbr_pass(32'hFEFE_FEFE);
        do_load("rbr_fe_sb");
        check("rbr_fe_const", mapping_group_o, 32'h0000_1C2F);

        repeat (3) tick("idle");
        check("hold", mapping_group_o, 32'h0000_1C2F);

        // Mixed codes across all four counter positions.
        set_zp(32'd0);
        rbr_pass(32'hFEFE_FEFE);
        rbr_pass(32'hFEFE_FEFE);
        rbr_pass(32'hFCFC_FCFC);
        rbr_pass(32'hFCFC_FCFC);
        do_load("rbr_mix_sb");
        check("rbr_mix_const", mapping_group_o, 32'h0000_36C9);

        // Parallel mode, accumulate at counter position 1.
        mode_i = 1;
        buf_write_en_1_i = 1; output_i = 32'hFCFC_FCFC; tick("w1");
        buf_write_en_2_i = 1; output_i = 32'hFEFE_FEFE; tick("w2");
        buf_read_en_i = 1;      tick("read");
        shift_counter_en_i = 1; tick("shift");
        accum_buf_write_i = 1;  tick("accum");
        do_load("par_sb");
        check("par_const", mapping_group_o, 32'h0005_5AA0);

        // Load colliding with add, counter step and zero-point update.
        mode_i = 0;
        set_zp(32'd5);
        rbr_pass(32'hFEFE_FEFE);
        load_en_i = 1; accum_buf_write_i = 1; shift_counter_en_i = 1;
        zero_point_en_i = 1; zero_point_i = 32'd7;
        tick("collide_sb");
        check("collide_const", mapping_group_o, 32'h0000_0050);
        do_load("empty_sb");
        check("empty_const", mapping_group_o, 32'hFFFF_FFF9);
        accum_buf_write_i = 1; tick("accum_cnt0");
        do_load("cnt_cleared_sb");
        check("cnt_cleared_const", mapping_group_o, 32'h0000_004E);

        // Lane ordering and saturation: lanes 0..3 = FE, FC, F8, FF.
        set_zp(32'd0);
        buf_write_en_1_i = 1; output_i = 32'hFFF8_FCFE; tick("w1");
        buf_read_en_i = 1;     tick("read");
        accum_buf_write_i = 1; tick("accum");
        do_load("lane_order_sb");
        check("lane_order_const", mapping_group_o, 32'h0000_0039);

        // Reset mid-sequence discards the partial accumulation, counter and sum.
        rbr_pass(32'hFEFE_FEFE);
        rbr_pass(32'hFEFE_FEFE);
        rst_i = 1;
        #1;
        check("mid_reset_out", mapping_group_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 0;
        reset_model();
        accum_buf_write_i = 1; tick("accum_after_reset");
        buf_write_en_1_i = 1; output_i = 32'hFEFE_FEFE; tick("w1");
        buf_read_en_i = 1;     tick("read");
        accum_buf_write_i = 1; tick("accum");
        do_load("post_reset_sb");
        check("post_reset_const", mapping_group_o, 32'h0000_0055);

        // Randomised parallel passes against the model, including saturated lanes.
        mode_i = 1;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                wa[8*k +: 8] = 8'hFF << $urandom_range(0, 8);
                wb[8*k +: 8] = 8'hFF << $urandom_range(0, 8);
            end
            buf_write_en_1_i = 1; output_i = wa; tick("w1");
            buf_write_en_2_i = 1; output_i = wb; tick("w2");
            buf_read_en_i = 1; tick("read");
            for (int c = 0; c < 4; c++) begin
                accum_buf_write_i = ($urandom_range(0, 1) == 1);
                shift_counter_en_i = 1;
                tick("rand_accum");
            end
            load_en_i = 1;
            zero_point_en_i = 1; zero_point_i = $urandom;
            tick("rand_load_sb");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
